// File: rtl/core_id_stage_pkg.sv
// Shared decode definitions for the instruction-decode stage.
// Contents:
//   - RV32I opcode, func3 and func7 constants
//   - ZeroWord, ZeroReg, WriteEnable and WriteDisable
//   - Immediate-select enum and operand-select enums
package core_id_stage_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;

  localparam logic [6:0] F7_BASE    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;

  localparam logic [31:0] ZeroWord     = 32'h0000_0000;
  localparam logic [4:0]  ZeroReg      = 5'd0;
  localparam logic        WriteEnable  = 1'b1;
  localparam logic        WriteDisable = 1'b0;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J,
    IMM_SHAMT
  } imm_sel_e;

  typedef enum logic [1:0] {A_RS1, A_PC, A_ZERO} opa_sel_e;
  typedef enum logic [1:0] {B_RS2, B_IMM, B_FOUR, B_ZERO} opb_sel_e;

endpackage

// File: rtl/core_imm_gen.sv
// Combinational immediate generator.
// Ports:
//   inst_i  instruction bits [31:7] (the opcode field carries no immediate bits)
//   sel_i   immediate format select
//   imm_o   XLEN-wide, sign-extended immediate (zero for IMM_NONE)
module core_imm_gen
  import core_id_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:7]     inst_i,
  input  imm_sel_e        sel_i,
  output logic [XLEN-1:0] imm_o
);

  logic [31:0] imm32;

  always_comb begin
    imm32 = ZeroWord;
    case (sel_i)
      IMM_I:     imm32 = {{20{inst_i[31]}}, inst_i[31:20]};
      IMM_S:     imm32 = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
      IMM_B:     imm32 = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25],
                          inst_i[11:8], 1'b0};
      IMM_U:     imm32 = {inst_i[31:12], 12'b0};
      IMM_J:     imm32 = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20],
                          inst_i[30:21], 1'b0};
      IMM_SHAMT: imm32 = {27'b0, inst_i[24:20]};
      default:   imm32 = ZeroWord;
    endcase
  end

  // Widen to XLEN by sign extension (identity for XLEN == 32).
  assign imm_o = XLEN'($signed(imm32));

endmodule

// File: rtl/core_id_stage.sv
// RV32I instruction-decode stage: decodes the IF/ID instruction, selects the
// immediate, muxes operands and registers the bundle into one output slot
// with valid/ready flow control. Stalls on load-use hazards, killed by flush.
// Optional macro CORE_ID_BYPASS_EN adds a write-back bypass
// (wb_we_in, wb_rd_in, wb_data_in) ahead of the operand muxes; without it the
// register file is expected to write through internally.
// Ports:
//   clk, rst              clock, asynchronous active-low reset
//   in_valid/in_ready     input handshake; inst_in, inst_addr_in
//   rs1/rs2_addr_out      register-file read addresses (combinational)
//   rs1/rs2_data_in       register-file read data, same cycle
//   ex_load_valid_in/rd   load in EX, for load-use stall
//   flush_in              kill the input and the output slot
//   out_valid/out_ready   output handshake; registered bundle below
//   pc_out, opnum1_out, opnum2_out, rs2_val_out, imm_out, rd_out,
//   reg_we_out, opcode_out, func3_out, func7_out, illegal_out
module core_id_stage
  import core_id_stage_pkg::*;
#(
  parameter int          XLEN     = 32,
  parameter int          REG_AW   = 5,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
`ifdef CORE_ID_BYPASS_EN
  input  logic              wb_we_in,
  input  logic [REG_AW-1:0] wb_rd_in,
  input  logic [XLEN-1:0]   wb_data_in,
`endif
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       inst_in,
  input  logic [XLEN-1:0]   inst_addr_in,
  output logic [REG_AW-1:0] rs1_addr_out,
  output logic [REG_AW-1:0] rs2_addr_out,
  input  logic [XLEN-1:0]   rs1_data_in,
  input  logic [XLEN-1:0]   rs2_data_in,
  input  logic              ex_load_valid_in,
  input  logic [REG_AW-1:0] ex_load_rd_in,
  input  logic              flush_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   pc_out,
  output logic [XLEN-1:0]   opnum1_out,
  output logic [XLEN-1:0]   opnum2_out,
  output logic [XLEN-1:0]   rs2_val_out,
  output logic [XLEN-1:0]   imm_out,
  output logic [REG_AW-1:0] rd_out,
  output logic              reg_we_out,
  output logic [6:0]        opcode_out,
  output logic [2:0]        func3_out,
  output logic [6:0]        func7_out,
  output logic              illegal_out
);

  logic [6:0]        opcode;
  logic [2:0]        func3;
  logic [6:0]        func7;
  logic [REG_AW-1:0] rd_addr;

  assign opcode       = inst_in[6:0];
  assign func3        = inst_in[14:12];
  assign func7        = inst_in[31:25];
  assign rd_addr      = REG_AW'(inst_in[11:7]);
  assign rs1_addr_out = REG_AW'(inst_in[19:15]);
  assign rs2_addr_out = REG_AW'(inst_in[24:20]);

  // Decode control
  imm_sel_e imm_sel;
  opa_sel_e a_sel;
  opb_sel_e b_sel;
  logic     we_raw, ill, use_rs1, use_rs2;

  always_comb begin
    imm_sel = IMM_NONE;
    a_sel   = A_RS1;
    b_sel   = B_RS2;
    we_raw  = WriteDisable;
    ill     = 1'b0;
    use_rs1 = 1'b1;
    use_rs2 = 1'b0;
    case (opcode)
      OPC_OP: begin
        use_rs2 = 1'b1;
        we_raw  = WriteEnable;
        ill     = (func7 != F7_BASE) && (func7 != F7_ALT);
      end
      OPC_OP_IMM: begin
        b_sel   = B_IMM;
        imm_sel = IMM_I;
        we_raw  = WriteEnable;
        if (func3 == F3_SLL) begin
          imm_sel = IMM_SHAMT;
          ill     = (func7 != F7_BASE);
        end else if (func3 == F3_SRL_SRA) begin
          imm_sel = IMM_SHAMT;
          ill     = (func7 != F7_BASE) && (func7 != F7_ALT);
        end
      end
      OPC_LOAD: begin
        b_sel = B_IMM; imm_sel = IMM_I; we_raw = WriteEnable;
      end
      OPC_STORE: begin
        b_sel = B_IMM; imm_sel = IMM_S; use_rs2 = 1'b1;
      end
      OPC_BRANCH: begin
        b_sel = B_RS2; imm_sel = IMM_B; use_rs2 = 1'b1;
      end
      OPC_LUI: begin
        a_sel = A_ZERO; b_sel = B_IMM; imm_sel = IMM_U;
        use_rs1 = 1'b0; we_raw = WriteEnable;
      end
      OPC_AUIPC: begin
        a_sel = A_PC; b_sel = B_IMM; imm_sel = IMM_U;
        use_rs1 = 1'b0; we_raw = WriteEnable;
      end
      OPC_JAL: begin
        a_sel = A_PC; b_sel = B_FOUR; imm_sel = IMM_J;
        use_rs1 = 1'b0; we_raw = WriteEnable;
      end
      OPC_JALR: begin
        b_sel = B_FOUR; imm_sel = IMM_I; we_raw = WriteEnable;
      end
      OPC_FENCE, OPC_SYSTEM: begin
        b_sel = B_IMM; imm_sel = IMM_I;
      end
      default: begin
        // Also catches inst[1:0] != 2'b11: every listed opcode ends in 11.
        ill   = 1'b1;
        a_sel = A_ZERO;
        b_sel = B_ZERO;
      end
    endcase
  end

  logic [XLEN-1:0] imm;

  core_imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .inst_i (inst_in[31:7]),
    .sel_i  (imm_sel),
    .imm_o  (imm)
  );

  // Source values
  logic [XLEN-1:0] rs1_val, rs2_val;
`ifdef CORE_ID_BYPASS_EN
  assign rs1_val = (wb_we_in && wb_rd_in != ZeroReg && wb_rd_in == rs1_addr_out)
                   ? wb_data_in : rs1_data_in;
  assign rs2_val = (wb_we_in && wb_rd_in != ZeroReg && wb_rd_in == rs2_addr_out)
                   ? wb_data_in : rs2_data_in;
`else
  assign rs1_val = rs1_data_in;
  assign rs2_val = rs2_data_in;
`endif

  logic [XLEN-1:0] opa, opb;

  always_comb begin
    case (a_sel)
      A_RS1:   opa = rs1_val;
      A_PC:    opa = inst_addr_in;
      default: opa = '0;
    endcase
    case (b_sel)
      B_RS2:   opb = rs2_val;
      B_IMM:   opb = imm;
      B_FOUR:  opb = XLEN'(4);
      default: opb = '0;
    endcase
  end

  logic reg_we;
  assign reg_we = we_raw && !ill && (rd_addr != ZeroReg);

  // Load-use hazard: only sources the opcode actually reads can stall.
  logic hazard;
  assign hazard = in_valid && ex_load_valid_in && (ex_load_rd_in != ZeroReg) &&
                  ((use_rs1 && ex_load_rd_in == rs1_addr_out) ||
                   (use_rs2 && ex_load_rd_in == rs2_addr_out));

  logic valid_q;
  logic accept;

  // Held low while in reset so the stage only opens once reset is released.
  assign in_ready = rst && !flush_in && !hazard && (!valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  // Output slot
  logic [XLEN-1:0]   pc_q, opa_q, opb_q, rs2v_q, imm_q;
  logic [REG_AW-1:0] rd_q;
  logic              we_q, ill_q;
  logic [6:0]        opc_q, f7_q;
  logic [2:0]        f3_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      pc_q    <= XLEN'(RESET_PC);
      opa_q   <= '0;
      opb_q   <= '0;
      rs2v_q  <= '0;
      imm_q   <= '0;
      rd_q    <= '0;
      we_q    <= WriteDisable;
      opc_q   <= '0;
      f3_q    <= '0;
      f7_q    <= '0;
      ill_q   <= 1'b0;
    end else if (flush_in) begin
      valid_q <= 1'b0;
    end else if (accept) begin
      valid_q <= 1'b1;
      pc_q    <= inst_addr_in;
      opa_q   <= opa;
      opb_q   <= opb;
      rs2v_q  <= rs2_val;
      imm_q   <= imm;
      rd_q    <= rd_addr;
      we_q    <= reg_we;
      opc_q   <= opcode;
      f3_q    <= func3;
      f7_q    <= func7;
      ill_q   <= ill;
    end else if (!(valid_q && !out_ready)) begin
      // Slot consumed or empty with nothing accepted: bubble.
      valid_q <= 1'b0;
    end
  end

  assign out_valid   = valid_q;
  assign pc_out      = pc_q;
  assign opnum1_out  = opa_q;
  assign opnum2_out  = opb_q;
  assign rs2_val_out = rs2v_q;
  assign imm_out     = imm_q;
  assign rd_out      = rd_q;
  assign reg_we_out  = we_q;
  assign opcode_out  = opc_q;
  assign func3_out   = f3_q;
  assign func7_out   = f7_q;
  assign illegal_out = ill_q;

endmodule

// File: tb/tb_core_id_stage.sv
module tb_core_id_stage;

  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic        clk, rst_n;
  logic        in_valid, in_ready;
  logic [31:0] inst_in, inst_addr_in;
  logic [4:0]  rs1_addr_out, rs2_addr_out;
  logic [31:0] rs1_data_in, rs2_data_in;
  logic        ex_load_valid_in;
  logic [4:0]  ex_load_rd_in;
  logic        flush_in;
  logic        out_valid, out_ready;
  logic [31:0] pc_out, opnum1_out, opnum2_out, rs2_val_out, imm_out;
  logic [4:0]  rd_out;
  logic        reg_we_out;
  logic [6:0]  opcode_out, func7_out;
  logic [2:0]  func3_out;
  logic        illegal_out;

  core_id_stage #(.XLEN(32), .REG_AW(5), .RESET_PC(RST_PC)) dut (
    .clk(clk), .rst(rst_n),
`ifdef CORE_ID_BYPASS_EN
    .wb_we_in(1'b0), .wb_rd_in(5'd0), .wb_data_in(32'd0),
`endif
    .in_valid(in_valid), .in_ready(in_ready), .inst_in(inst_in),
    .inst_addr_in(inst_addr_in), .rs1_addr_out(rs1_addr_out),
    .rs2_addr_out(rs2_addr_out), .rs1_data_in(rs1_data_in),
    .rs2_data_in(rs2_data_in), .ex_load_valid_in(ex_load_valid_in),
    .ex_load_rd_in(ex_load_rd_in), .flush_in(flush_in),
    .out_valid(out_valid), .out_ready(out_ready), .pc_out(pc_out),
    .opnum1_out(opnum1_out), .opnum2_out(opnum2_out),
    .rs2_val_out(rs2_val_out), .imm_out(imm_out), .rd_out(rd_out),
    .reg_we_out(reg_we_out), .opcode_out(opcode_out),
    .func3_out(func3_out), .func7_out(func7_out), .illegal_out(illegal_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc, a, b, r2, imm;
    logic [4:0]  rd;
    logic        we;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        ill;
  } exp_t;

  exp_t        q[$];
  int          checks = 0, failures = 0;
  logic [31:0] rf [32];
  bit          slot = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Reference decode from the RV32I rules.
  function automatic exp_t ref_dec(logic [31:0] i, logic [31:0] pc,
                                   logic [31:0] r1, logic [31:0] r2);
    exp_t e;
    logic [31:0] iI, iS, iB, iU, iJ;
    iI = 32'($signed(i[31:20]));
    iS = 32'($signed({i[31:25], i[11:7]}));
    iB = 32'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0}));
    iU = {i[31:12], 12'b0};
    iJ = 32'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0}));
    e = '0;
    e.pc = pc; e.r2 = r2; e.rd = i[11:7];
    e.opc = i[6:0]; e.f3 = i[14:12]; e.f7 = i[31:25];
    case (i[6:0])
      7'h33: begin e.a = r1; e.b = r2; e.we = 1;
                   e.ill = !(e.f7 == 7'h00 || e.f7 == 7'h20); end
      7'h13: begin
        e.a = r1; e.we = 1;
        if (e.f3 == 3'd1) begin e.imm = {27'b0, i[24:20]}; e.ill = (e.f7 != 7'h00); end
        else if (e.f3 == 3'd5) begin
          e.imm = {27'b0, i[24:20]}; e.ill = !(e.f7 == 7'h00 || e.f7 == 7'h20);
        end else e.imm = iI;
        e.b = e.imm;
      end
      7'h03: begin e.a = r1; e.b = iI; e.imm = iI; e.we = 1; end
      7'h23: begin e.a = r1; e.b = iS; e.imm = iS; end
      7'h63: begin e.a = r1; e.b = r2; e.imm = iB; end
      7'h37: begin e.a = 0;  e.b = iU; e.imm = iU; e.we = 1; end
      7'h17: begin e.a = pc; e.b = iU; e.imm = iU; e.we = 1; end
      7'h6f: begin e.a = pc; e.b = 4;  e.imm = iJ; e.we = 1; end
      7'h67: begin e.a = r1; e.b = 4;  e.imm = iI; e.we = 1; end
      7'h73, 7'h0f: begin e.a = r1; e.b = iI; e.imm = iI; end
      default: e.ill = 1;
    endcase
    if (e.ill || e.rd == 0) e.we = 0;
    return e;
  endfunction

  function automatic bit hz(logic [31:0] i, bit ldv, logic [4:0] ldrd);
    bit u1, u2;
    u1 = !(i[6:0] inside {7'h37, 7'h17, 7'h6f});
    u2 = i[6:0] inside {7'h33, 7'h23, 7'h63};
    return ldv && ldrd != 0 && ((u1 && ldrd == i[19:15]) || (u2 && ldrd == i[24:20]));
  endfunction

  function automatic logic [31:0] gen();
    logic [31:0] i;
    int k;
    i = $urandom;
    k = $urandom_range(0, 12);
    case (k)
      0: i[6:0] = 7'h33;  1: i[6:0] = 7'h13;  2: i[6:0] = 7'h03;
      3: i[6:0] = 7'h23;  4: i[6:0] = 7'h63;  5: i[6:0] = 7'h37;
      6: i[6:0] = 7'h17;  7: i[6:0] = 7'h6f;  8: i[6:0] = 7'h67;
      9: i[6:0] = 7'h73; 10: i[6:0] = 7'h0f;
      11: ;
      default: i[6:0] = {5'b01100, 2'($urandom_range(0, 2))};
    endcase
    if (k <= 1) begin
      case ($urandom_range(0, 2))
        0: i[31:25] = 7'h00;
        1: i[31:25] = 7'h20;
        default: ;
      endcase
    end
    if ($urandom_range(0, 1) == 1) begin
      i[19:15] = 5'($urandom_range(0, 3));
      i[24:20] = 5'($urandom_range(0, 3));
    end
    return i;
  endfunction

  // One clock cycle of stimulus plus the model's view of the handshake.
  task automatic cyc(input logic [31:0] inst, input logic [31:0] pc, input bit vld,
                     input bit ldv, input logic [4:0] ldrd, input bit fl, input bit ordy);
    bit rdy, acc;
    inst_in = inst; inst_addr_in = pc; in_valid = vld;
    rs1_data_in = rf[inst[19:15]]; rs2_data_in = rf[inst[24:20]];
    ex_load_valid_in = ldv; ex_load_rd_in = ldrd; flush_in = fl; out_ready = ordy;
    rdy = !fl && !(vld && hz(inst, ldv, ldrd)) && (!slot || ordy);
    acc = vld && rdy;
    @(negedge clk);
    chk("in_ready", 64'(in_ready), 64'(rdy));
    chk("out_valid", 64'(out_valid), 64'(slot));
    chk("rs_addr", 64'({rs1_addr_out, rs2_addr_out}), 64'({inst[19:15], inst[24:20]}));
    @(posedge clk);
    if (acc) q.push_back(ref_dec(inst, pc, rf[inst[19:15]], rf[inst[24:20]]));
    if (fl) q.delete();
    slot = fl ? 1'b0 : acc ? 1'b1 : (slot && !ordy);
    #1;
  endtask

  // Monitor: every transfer on the output must match the oldest expectation.
  always @(negedge clk) begin
    exp_t a, e;
    if (rst_n && out_valid && out_ready) begin
      a.pc = pc_out; a.a = opnum1_out; a.b = opnum2_out; a.r2 = rs2_val_out;
      a.imm = imm_out; a.rd = rd_out; a.we = reg_we_out; a.opc = opcode_out;
      a.f3 = func3_out; a.f7 = func7_out; a.ill = illegal_out;
      checks++;
      if (q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_bundle actual pc=%h op=%h required none", pc_out, opcode_out);
      end else begin
        e = q.pop_front();
        if (a !== e) begin
          failures++;
          $display("FAIL bundle actual pc=%h a=%h b=%h r2=%h imm=%h rd=%0d we=%b opc=%h f3=%h f7=%h ill=%b required pc=%h a=%h b=%h r2=%h imm=%h rd=%0d we=%b opc=%h f3=%h f7=%h ill=%b",
                   a.pc, a.a, a.b, a.r2, a.imm, a.rd, a.we, a.opc, a.f3, a.f7, a.ill,
                   e.pc, e.a, e.b, e.r2, e.imm, e.rd, e.we, e.opc, e.f3, e.f7, e.ill);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; in_valid = 0; inst_in = 0; inst_addr_in = 0;
    rs1_data_in = 0; rs2_data_in = 0; ex_load_valid_in = 0; ex_load_rd_in = 0;
    flush_in = 0; out_ready = 0;
    for (int k = 0; k < 32; k++) rf[k] = $urandom;
    rf[0] = 0; rf[1] = 32'd10; rf[2] = 32'h55;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_pc", 64'(pc_out), 64'(RST_PC));
    chk("rst_regs", 64'({opnum1_out, imm_out}), 64'd0);
    chk("rst_ctl", 64'({reg_we_out, illegal_out, rd_out, opcode_out}), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // ADDI x5,x1,-3
    cyc(32'hFFD08293, 32'h1000, 1, 0, 0, 0, 1);
    chk("addi_op1", 64'(opnum1_out), 64'd10);
    chk("addi_op2", 64'(opnum2_out), 64'hFFFF_FFFD);
    chk("addi_rd_we", 64'({rd_out, reg_we_out}), 64'({5'd5, 1'b1}));
    // SW x2,8(x1) then BEQ x1,x2,-4
    cyc(32'h0020A423, 32'h1004, 1, 0, 0, 0, 1);
    chk("sw_imm", 64'({imm_out, rs2_val_out}), 64'({32'd8, 32'h55}));
    cyc(32'hFE208EE3, 32'h1008, 1, 0, 0, 0, 1);
    chk("beq_imm", 64'({imm_out, 31'd0, reg_we_out}), 64'({32'hFFFF_FFFC, 32'd0}));
    // ADD x3,x1,x2 behind a load to x1, then with the load gone
    cyc(32'h002081B3, 32'h100C, 1, 1, 5'd1, 0, 1);
    cyc(32'h002081B3, 32'h100C, 1, 0, 0, 0, 1);
    // Backpressure: slot holds ADDI x1,x0,1 for 3 cycles, then release
    cyc(32'h00100093, 32'h1010, 1, 0, 0, 0, 1);
    repeat (3) begin
      cyc(32'h00208133, 32'h1014, 1, 0, 0, 0, 0);
      chk("hold_pc", 64'({pc_out, opnum2_out}), 64'({32'h1010, 32'd1}));
    end
    cyc(32'h00208133, 32'h1014, 1, 0, 0, 0, 1);
    // Flush with a full slot and a pending instruction
    cyc(32'h00308193, 32'h1018, 1, 0, 0, 1, 0);
    cyc(32'h0, 32'h0, 0, 0, 0, 0, 1);
    // Unknown opcode, then LUI x0
    cyc(32'h0000007F, 32'h2000, 1, 0, 0, 0, 1);
    chk("illegal", 64'({illegal_out, reg_we_out}), 64'({1'b1, 1'b0}));
    cyc(32'h12345037, 32'h2004, 1, 0, 0, 0, 1);
    chk("lui_x0", 64'({opnum2_out, 31'd0, reg_we_out}), 64'({32'h1234_5000, 32'd0}));
    cyc(32'h0, 32'h0, 0, 0, 0, 0, 1);

    // Randomized traffic
    repeat (600) begin
      cyc(gen(), {$urandom} & 32'hFFFF_FFFC,
          $urandom_range(0, 9) < 8, $urandom_range(0, 9) < 3,
          5'($urandom_range(0, 3)), $urandom_range(0, 19) == 0,
          $urandom_range(0, 9) < 7);
    end

    repeat (4) cyc(32'h0, 32'h0, 0, 0, 0, 0, 1);
    chk("drained", 64'(q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
